// File: rtl/exp7_pkg.sv
// Shared state encoding for the memory-game sequence presenter.
package exp7_pkg;

  localparam logic [3:0] S_OCIOSO  = 4'd0;
  localparam logic [3:0] S_CARREGA = 4'd1;
  localparam logic [3:0] S_ACENDE  = 4'd2;
  localparam logic [3:0] S_APAGA   = 4'd3;
  localparam logic [3:0] S_PROXIMO = 4'd4;
  localparam logic [3:0] S_FIM     = 4'd5;

  // Debug code shown when the state register holds an unused value
  localparam logic [3:0] DB_INVALIDO = 4'hF;

endpackage

// File: rtl/contador_m.sv
// Generic modulo-M up counter with synchronous clear (priority) and enable.
module contador_m #(
  parameter int W = 4,
  parameter int M = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] Q,
  output logic         fim
);

  logic [W-1:0] r_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (zera) begin
      r_q <= '0;
    end else if (conta) begin
      if (r_q == W'(M - 1)) r_q <= '0;
      else                  r_q <= r_q + 1'b1;
    end
  end

  assign Q   = r_q;
  assign fim = (r_q == W'(M - 1));

endmodule

// File: rtl/exibe_sequencia_exp7.sv
// Shows the stored sequence on the LEDs (on-time then dark gap per value) and
// pulses pronto after the last address of the round has been shown.
module exibe_sequencia_exp7
  import exp7_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int T_ON   = 500,
  parameter int T_OFF  = 250
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] ultimo_endereco,
  input  logic [DATA_W-1:0] mem_dado,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] leds,
  output logic              exibindo,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  logic [3:0]        r_estado;
  logic [3:0]        w_prox;
  logic [ADDR_W-1:0] r_ultimo;
  logic [DATA_W-1:0] r_leds;
  logic [ADDR_W-1:0] w_addr;
  logic              w_addr_fim;
  logic              w_addr_zera;
  logic              w_addr_conta;
  logic [TW-1:0]     w_tmr;
  logic              w_tmr_fim;
  logic              w_tmr_zera;
  logic              w_tmr_conta;
  logic              w_tmr_done;
  logic              w_ultimo;

  // Both counters saturate at their modulus limit instead of wrapping
  assign w_addr_zera  = (r_estado == S_OCIOSO) && iniciar;
  assign w_addr_conta = (r_estado == S_PROXIMO) && !w_addr_fim;

  contador_m #(.W(ADDR_W), .M(2 ** ADDR_W)) u_endereco (
    .clock (clock),
    .reset (reset),
    .zera  (w_addr_zera),
    .conta (w_addr_conta),
    .Q     (w_addr),
    .fim   (w_addr_fim)
  );

  always_comb begin
    w_tmr_done = 1'b0;
    case (r_estado)
      S_ACENDE: w_tmr_done = (w_tmr == TW'(T_ON - 1));
      S_APAGA:  w_tmr_done = (w_tmr == TW'(T_OFF - 1));
      default:  w_tmr_done = 1'b0;
    endcase
  end

  assign w_tmr_zera  = (r_estado == S_CARREGA) || ((r_estado == S_ACENDE) && w_tmr_done);
  assign w_tmr_conta = ((r_estado == S_ACENDE) || (r_estado == S_APAGA)) && !w_tmr_fim;

  contador_m #(.W(TW), .M(T_MAX)) u_timer (
    .clock (clock),
    .reset (reset),
    .zera  (w_tmr_zera),
    .conta (w_tmr_conta),
    .Q     (w_tmr),
    .fim   (w_tmr_fim)
  );

  assign w_ultimo = (w_addr == r_ultimo);

  always_comb begin
    w_prox = S_OCIOSO;
    case (r_estado)
      S_OCIOSO:  w_prox = iniciar ? S_CARREGA : S_OCIOSO;
      S_CARREGA: w_prox = S_ACENDE;
      S_ACENDE:  w_prox = w_tmr_done ? S_APAGA : S_ACENDE;
      S_APAGA:   w_prox = w_tmr_done ? (w_ultimo ? S_FIM : S_PROXIMO) : S_APAGA;
      S_PROXIMO: w_prox = S_CARREGA;
      S_FIM:     w_prox = S_OCIOSO;
      default:   w_prox = S_OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= S_OCIOSO;
      r_ultimo <= '0;
      r_leds   <= '0;
    end else begin
      r_estado <= w_prox;
      if ((r_estado == S_OCIOSO) && iniciar) r_ultimo <= ultimo_endereco;
      if (r_estado == S_CARREGA)                     r_leds <= mem_dado;
      else if ((r_estado == S_ACENDE) && w_tmr_done) r_leds <= '0;
    end
  end

  always_comb begin
    db_estado = DB_INVALIDO;
    case (r_estado)
      S_OCIOSO, S_CARREGA, S_ACENDE, S_APAGA, S_PROXIMO, S_FIM: db_estado = r_estado;
      default: db_estado = DB_INVALIDO;
    endcase
  end

  assign mem_endereco = w_addr;
  assign leds         = r_leds;
  assign exibindo     = (r_estado != S_OCIOSO);
  assign pronto       = (r_estado == S_FIM);

endmodule

// File: tb/tb_exibe_sequencia_exp7.sv
// Bench for the sequence presenter with T_ON=4, T_OFF=2 (8 cycles per value).
module tb_exibe_sequencia_exp7;

  localparam int W = 14;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [3:0] ultimo_endereco;
  logic [3:0] mem_dado;
  logic [3:0] mem_endereco;
  logic [3:0] leds;
  logic       exibindo;
  logic       pronto;
  logic [3:0] db_estado;

  logic [3:0]   mem [16];
  logic [W-1:0] exp_q [$];
  logic [3:0]   idle_addr;
  int           checks;
  int           errors;

  assign mem_dado = mem[mem_endereco];

  exibe_sequencia_exp7 #(.ADDR_W(4), .DATA_W(4), .T_ON(4), .T_OFF(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .iniciar         (iniciar),
    .ultimo_endereco (ultimo_endereco),
    .mem_dado        (mem_dado),
    .mem_endereco    (mem_endereco),
    .leds            (leds),
    .exibindo        (exibindo),
    .pronto          (pronto),
    .db_estado       (db_estado)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion before 100000");
    $fatal(1, "timeout");
  end

  // expected entry: {db_estado, exibindo, pronto, leds, mem_endereco}
  function automatic void push_e(logic [3:0] db, logic ex, logic pr, logic [3:0] ld, logic [3:0] ad);
    exp_q.push_back({db, ex, pr, ld, ad});
  endfunction

  function automatic void push_run(int last, logic [3:0] start_addr);
    logic [3:0] aa;
    push_e(4'd0, 1'b0, 1'b0, 4'h0, start_addr);
    for (int a = 0; a <= last; a++) begin
      aa = 4'(a);
      push_e(4'd1, 1'b1, 1'b0, 4'h0, aa);
      for (int k = 0; k < 4; k++) push_e(4'd2, 1'b1, 1'b0, mem[aa], aa);
      for (int k = 0; k < 2; k++) push_e(4'd3, 1'b1, 1'b0, 4'h0, aa);
      if (a == last) push_e(4'd5, 1'b1, 1'b1, 4'h0, aa);
      else           push_e(4'd4, 1'b1, 1'b0, 4'h0, aa);
    end
    push_e(4'd0, 1'b0, 1'b0, 4'h0, 4'(last));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {db_estado, exibindo, pronto, leds, mem_endereco};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL trace @%0t: got db=%h ex=%b pr=%b leds=%h addr=%h, required db=%h ex=%b pr=%b leds=%h addr=%h",
                   $time, act[13:10], act[9], act[8], act[7:4], act[3:0],
                   e[13:10], e[9], e[8], e[7:4], e[3:0]);
        end
      end
    end
  end

  task automatic push_idle(int n);
    for (int i = 0; i < n; i++) push_e(4'd0, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  // driver: one display run; chg_at pulses iniciar/changes ultimo, rst_at resets mid-run
  task automatic run(int last, int exp_cyc, int chg_at, int rst_at);
    int cyc;
    int got;
    bit stop;
    @(posedge clock); #1;
    ultimo_endereco = 4'(last);
    iniciar = 1'b1;
    push_run(last, idle_addr);
    @(posedge clock); #1;
    iniciar = 1'b0;
    cyc  = 1;
    got  = 0;
    stop = 0;
    while (cyc <= 300 && got == 0 && !stop) begin
      if (cyc == rst_at) begin
        reset = 1'b0;
        #1;
        check("reset_mid_leds", 32'(leds), 32'h0);
        check("reset_mid_exibindo", 32'(exibindo), 32'h0);
        check("reset_mid_db_estado", 32'(db_estado), 32'h0);
        check("reset_mid_addr", 32'(mem_endereco), 32'h0);
        check("reset_mid_pronto", 32'(pronto), 32'h0);
        exp_q.delete();
        stop = 1;
      end else begin
        if (cyc == chg_at) begin
          iniciar = 1'b1;
          ultimo_endereco = 4'd5;
        end else if (cyc == chg_at + 1) begin
          iniciar = 1'b0;
        end
        @(negedge clock);
        if (pronto) got = cyc;
        @(posedge clock); #1;
        cyc++;
      end
    end
    if (stop) begin
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;
      push_idle(30);
      repeat (30) @(negedge clock);
      idle_addr = 4'h0;
    end else begin
      check("pronto_cycle", 32'(got), 32'(exp_cyc));
      @(negedge clock);
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      idle_addr = 4'(last);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    iniciar = 1'b0;
    ultimo_endereco = 4'h0;
    idle_addr = 4'h0;
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;

    repeat (3) @(posedge clock);
    #1;
    check("reset_leds", 32'(leds), 32'h0);
    check("reset_addr", 32'(mem_endereco), 32'h0);
    check("reset_exibindo", 32'(exibindo), 32'h0);
    check("reset_pronto", 32'(pronto), 32'h0);
    check("reset_db_estado", 32'(db_estado), 32'h0);
    reset = 1'b1;
    push_idle(20);
    repeat (20) @(negedge clock);

    mem[0] = 4'b0010;
    run(0, 8, -10, -10);

    mem[0] = 4'b0001;
    mem[1] = 4'b0100;
    mem[2] = 4'b1000;
    run(2, 24, -10, -10);
    run(2, 24, 12, -10);
    run(2, 24, -10, 11);
    run(2, 24, -10, -10);

    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    run(15, 128, -10, -10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exibe_sequencia_exp7.md
# exibe_sequencia_exp7

Sequence presenter for the memory game: on command from the main game control unit, it reads the stored sequence from address 0 up to the current round's last address. It shows each stored value on the LEDs for a fixed on-time, followed by a dark gap. When the last value has been shown it returns a one-cycle `pronto` pulse. It is the output-side counterpart of the player-input/compare path and occupies the main control unit's sequence-display phase.

## Interface
Parameters:
- `ADDR_W`, 4: sequence memory address width.
- `DATA_W`, 4: sequence value / LED width (one-hot LED code as stored).
- `T_ON`, 500: LED on-time in clock cycles, ≥1.
- `T_OFF`, 250: dark gap after each value in clock cycles, ≥1.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `iniciar`  in  1  start request from main control unit; sampled only in `ocioso`.
- `ultimo_endereco`  in  ADDR_W  last address to show this round; latched when `iniciar` is accepted.
- `mem_dado`  in  DATA_W  sequence memory read data, combinational from `mem_endereco`.
- `mem_endereco`  out  ADDR_W  sequence memory address.
- `leds`  out  DATA_W  registered LED drive.
- `exibindo`  out  1  high in every state except `ocioso`.
- `pronto`  out  1  one-cycle pulse, high in `fim` only.
- `db_estado`  out  4  current state code (debug).

## Operation
- States and codes: `ocioso` (0), `carrega` (1), `acende` (2), `apaga` (3), `proximo` (4), `fim` (5). Unused codes go to `ocioso`; `db_estado` = F for unused codes.
- Transitions:
  - `ocioso`: `iniciar`=1 → `carrega`. On that edge, clear the address counter and latch `ultimo_endereco`.
  - `carrega`: capture `mem_dado` into the LED register and clear the timer → `acende`.
  - `acende`: `leds` = captured value. The timer counts. At count `T_ON-1`, clear the timer → `apaga`.
  - `apaga`: `leds` = 0. The timer counts. At count `T_OFF-1`:
    - if address == latched last address → `fim`;
    - otherwise → `proximo`.
  - `proximo`: address +1 → `carrega`.
  - `fim`: `pronto`=1 → `ocioso`.
- `iniciar` is ignored in every state except `ocioso`. A change of `ultimo_endereco` during display has no effect.
- `ultimo_endereco`=0 shows exactly one value.
- `ultimo_endereco` = all-ones shows 2^ADDR_W values. The address counter must not wrap before the compare.
- `mem_endereco` = address counter in all states; it is 0 in `ocioso` after reset.
- Timer width is clog2(max(T_ON,T_OFF)).

## Timing
- Reset values: state `ocioso`, `leds`=0, `mem_endereco`=0, `exibindo`=0, `pronto`=0, `db_estado`=0. The timer and latched last address are also 0.
- Reset asserted mid-display forces all outputs to their reset values immediately (asynchronously); there is no partial completion and no `pronto`.
- Cycle numbering: edge E0 samples `iniciar`=1.
  - Cycle 1 is `carrega`, with `exibindo`=1 from cycle 1.
  - First LED value is visible from cycle 2.
- Per value: 1 (`carrega`) + `T_ON` + `T_OFF` + 1 (`proximo` or `fim`) cycles.
- For N = `ultimo_endereco`+1, `pronto` is high in cycle N·(`T_ON`+`T_OFF`+2) only. `exibindo` falls in the following cycle.
- `iniciar` held high through `fim` restarts on the edge after `fim` (first edge seen in `ocioso`).
- Memory read is combinational, so data is valid in `carrega` because the address has been stable since the previous state.

## Structure
- Shared package `exp7_pkg`: state code constants (4-bit) and the 4'hF debug default.
- Sub-module `contador_m`: generic modulo counter with ports `clock`, `reset` (active-low async), `zera`, `conta`, `Q`, `fim`. Two instances:
  - address counter, width ADDR_W;
  - timer, modulo max(`T_ON`,`T_OFF`), with `fim` decoded per state.
- Top file holds the FSM, the last-address latch, the LED register and the compare.

## Test plan
Bench parameters: `T_ON`=4, `T_OFF`=2.
- Reset then idle: `reset`=0 for 3 cycles, then release with `iniciar`=0 → all outputs 0, `db_estado`=0, stable for 20 cycles.
- Single value: memory[0]=4'b0010, `ultimo_endereco`=0, pulse `iniciar` → `leds`=0010 in cycles 2–5, `leds`=0 in cycles 6–7, `pronto` high in cycle 8 only.
- Three values: memory = 0001, 0100, 1000, `ultimo_endereco`=2 → LED windows start at cycles 2, 10 and 18, each 4 cycles long; `mem_endereco` steps 0→1→2; `pronto` high in cycle 24.
- Ignore/latch: during the three-value run, pulse `iniciar` and change `ultimo_endereco` to 5 at cycle 12 → sequence and `pronto` timing unchanged from the previous case.
- Reset mid-operation: drive `reset`=0 at cycle 11 of the three-value run → `leds`=0, `exibindo`=0, `db_estado`=0 within the same cycle; no `pronto`. A new `iniciar` then runs normally.
- Full range: `ultimo_endereco`=15, memory[i]=i → 16 values shown in address order 0..15; `pronto` at cycle 128.
